// File: rtl/fwd_neuron_module_pkg.sv
// ============================================================================
// Module  : fwd_neuron_module_pkg
// Purpose : Q6.10 fixed-point constants and neuron FSM state encoding, shared
//           by the forward-propagation and back-propagation blocks.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fwd_neuron_module_pkg;

  // Q6.10 operand format
  localparam int                Q_W       = 16;
  localparam int                Q_FRAC    = 10;
  localparam int                Q_PROD_W  = 2 * Q_W;
  localparam logic signed [15:0] Q_SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q_SAT_MIN = 16'sh8000;

  // Neuron evaluation FSM encoding
  typedef logic [1:0] neuron_state_t;
  localparam neuron_state_t ST_IDLE   = 2'd0;
  localparam neuron_state_t ST_ACC    = 2'd1;
  localparam neuron_state_t ST_FINISH = 2'd2;

endpackage : fwd_neuron_module_pkg

`default_nettype wire

// File: rtl/fwd_neuron_module_q_sat.sv
// ============================================================================
// Module  : q_sat_module
// Purpose : Arithmetic right shift of a wide signed value (floor rounding)
//           followed by saturation into a signed 16-bit Q6.10 word.
// Ports   : d_i [IN_W] signed wide input
//           q_o [16]   signed saturated output
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module q_sat_module
  import fwd_neuron_module_pkg::*;
#(
  parameter int IN_W  = 36,
  parameter int SHIFT = Q_FRAC
) (
  input  logic signed [IN_W-1:0] d_i,
  output logic signed [Q_W-1:0]  q_o
);

  logic signed [IN_W-1:0]  w_shift;
  logic        [IN_W-Q_W:0] w_hi;

  assign w_shift = d_i >>> SHIFT;
  // The value fits in 16 bits only when every bit above bit 14 equals the sign.
  assign w_hi    = w_shift[IN_W-1:Q_W-1];

  always_comb begin
    q_o = w_shift[Q_W-1:0];
    if (!((&w_hi) || (~|w_hi))) begin
      q_o = w_shift[IN_W-1] ? Q_SAT_MIN : Q_SAT_MAX;
    end
  end

endmodule : q_sat_module

`default_nettype wire

// File: rtl/fwd_neuron_module.sv
// ============================================================================
// Module  : fwd_neuron_module
// Purpose : Single-neuron forward pass. Accumulates N_IN x*w products, adds
//           the bias, rescales to Q6.10 with saturation and applies ReLU.
// Ports   : clk, rst_n       clock, async active-low reset
//           step [4]         episode step; start only accepted when non-zero
//           start            request a new evaluation (ignored while busy)
//           in_valid         x_in/w_in beat valid
//           x_in, w_in [16]  Q6.10 activation / weight
//           bias [16]        Q6.10 bias, sampled in FINISH
//           busy             high in ACC and FINISH
//           z [16]           registered pre-activation
//           a1 [16]          registered ReLU(z)
//           a1_valid         one-cycle pulse when z/a1 update
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fwd_neuron_module
  import fwd_neuron_module_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int FRAC = Q_FRAC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         step,
  input  logic               start,
  input  logic               in_valid,
  input  logic signed [15:0] x_in,
  input  logic signed [15:0] w_in,
  input  logic signed [15:0] bias,
  output logic               busy,
  output logic signed [15:0] z,
  output logic signed [15:0] a1,
  output logic               a1_valid
);

  localparam int ACC_W = Q_PROD_W + $clog2(N_IN);
  localparam int SUM_W = ACC_W + 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_IN - 1);

  neuron_state_t state_q, state_d;

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic        [CNT_W-1:0]    cnt_q, cnt_d;
  logic signed [Q_W-1:0]      z_q, z_d;
  logic signed [Q_W-1:0]      a1_q, a1_d;
  logic                       a1_valid_q, a1_valid_d;

  logic signed [Q_PROD_W-1:0] w_prod;
  logic signed [SUM_W-1:0]    w_bias_sh;
  logic signed [SUM_W-1:0]    w_sum;
  logic signed [Q_W-1:0]      w_z_sat;
  logic                       w_beat;
  logic                       w_accept;

  assign w_accept  = (state_q == ST_IDLE) && start && (step != 4'd0);
  assign w_beat    = (state_q == ST_ACC) && in_valid;
  assign w_prod    = x_in * w_in;
  // Bias is aligned to the product scale (2*FRAC fractional bits).
  assign w_bias_sh = {{(SUM_W-Q_W-FRAC){bias[15]}}, bias, {FRAC{1'b0}}};
  assign w_sum     = {acc_q[ACC_W-1], acc_q} + w_bias_sh;

  q_sat_module #(
    .IN_W  (SUM_W),
    .SHIFT (FRAC)
  ) u_q_sat (
    .d_i (w_sum),
    .q_o (w_z_sat)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (w_accept) state_d = ST_ACC;
      ST_ACC:    if (w_beat && (cnt_q == LAST_BEAT)) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_q == ST_ACC) || (state_q == ST_FINISH);
  end

  // ---------------- Datapath next state ----------------
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    z_d        = z_q;
    a1_d       = a1_q;
    a1_valid_d = 1'b0;
    if (w_accept) begin
      acc_d = '0;
      cnt_d = '0;
    end
    if (w_beat) begin
      acc_d = acc_q + {{(ACC_W-Q_PROD_W){w_prod[Q_PROD_W-1]}}, w_prod};
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == ST_FINISH) begin
      z_d        = w_z_sat;
      a1_d       = w_z_sat[Q_W-1] ? '0 : w_z_sat;
      a1_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      z_q        <= '0;
      a1_q       <= '0;
      a1_valid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      z_q        <= z_d;
      a1_q       <= a1_d;
      a1_valid_q <= a1_valid_d;
    end
  end

  assign z        = z_q;
  assign a1       = a1_q;
  assign a1_valid = a1_valid_q;

endmodule : fwd_neuron_module

`default_nettype wire

// File: tb/tb_fwd_neuron_module.sv
// ============================================================================
// Module  : tb_fwd_neuron_module
// Purpose : Self-checking bench for fwd_neuron_module: directed vectors,
//           gap/abort/ignored-start cases and randomized evaluations against
//           an arithmetic reference model.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fwd_neuron_module;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  step;
  logic        start;
  logic        in_valid;
  logic [15:0] x_in;
  logic [15:0] w_in;
  logic [15:0] bias;
  logic        busy;
  logic [15:0] z;
  logic [15:0] a1;
  logic        a1_valid;

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;

  logic signed [15:0] xv [N];
  logic signed [15:0] wv [N];

  fwd_neuron_module #(.N_IN(N), .FRAC(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (step),
    .start    (start),
    .in_valid (in_valid),
    .x_in     (x_in),
    .w_in     (w_in),
    .bias     (bias),
    .busy     (busy),
    .z        (z),
    .a1       (a1),
    .a1_valid (a1_valid)
  );

  always #5 clk = ~clk;

  // a1_valid sampled at the rising edge holds the value of the cycle just ended
  always @(posedge clk) if (a1_valid) pulses <= pulses + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact sum of products plus scaled bias, floor-divided by 2^10, clamped.
  function automatic logic [15:0] ref_z(input logic signed [15:0] b);
    longint s;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(xv[i]) * longint'(wv[i]);
    s += longint'(b) * 1024;
    s = s >>> 10;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  function automatic logic [15:0] ref_a1(input logic [15:0] zz);
    return zz[15] ? 16'h0000 : zz;
  endfunction

  // Runs one evaluation from a falling edge. gap_len idle cycles are inserted
  // before beat gap_at; poke drives start during the gaps and on beat 1.
  task automatic run_eval(input string tag, input logic [15:0] b, input int gap_at,
                          input int gap_len, input bit poke);
    logic [15:0] ez, ea;
    int p0;
    ez = ref_z(b);
    ea = ref_a1(ez);
    p0 = pulses;
    bias  = b;
    step  = 4'($urandom_range(1, 15));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_busy_acc"}, 32'(busy), 32'd1);
    for (int i = 0; i < N; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          in_valid = 1'b0;
          x_in     = 16'($urandom);
          w_in     = 16'($urandom);
          start    = poke;
          @(negedge clk);
          check_eq({tag, "_busy_gap"}, 32'(busy), 32'd1);
        end
      end
      x_in     = xv[i];
      w_in     = wv[i];
      in_valid = 1'b1;
      start    = poke && (i == 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    x_in     = 16'($urandom);
    check_eq({tag, "_fin_busy"}, 32'(busy), 32'd1);
    check_eq({tag, "_fin_valid"}, 32'(a1_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, "_valid"}, 32'(a1_valid), 32'd1);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    check_eq({tag, "_z"}, 32'(z), 32'(ez));
    check_eq({tag, "_a1"}, 32'(a1), 32'(ea));
    bias = 16'($urandom);
    @(negedge clk);
    check_eq({tag, "_valid_drop"}, 32'(a1_valid), 32'd0);
    check_eq({tag, "_z_hold"}, 32'(z), 32'(ez));
    check_eq({tag, "_pulses"}, 32'(pulses - p0), 32'd1);
  endtask

  task automatic load_028();
    xv[0] = 16'sh0400; xv[1] = 16'sh0800; xv[2] = 16'sh0200; xv[3] = 16'shFC00;
    wv[0] = 16'sh0200; wv[1] = 16'sh0200; wv[2] = 16'sh0400; wv[3] = 16'sh0400;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    logic [15:0] zkeep;
    rst_n = 1'b0; step = 4'd0; start = 1'b0; in_valid = 1'b0;
    x_in = '0; w_in = '0; bias = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_z", 32'(z), 32'd0);
    check_eq("rst_a1", 32'(a1), 32'd0);
    check_eq("rst_valid", 32'(a1_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    load_028();
    run_eval("v028", 16'h0100, N, 0, 1'b0);
    check_eq("v028_exact", 32'(z), 32'h0500);
    for (int i = 0; i < N; i++) begin xv[i] = 16'shFC00; wv[i] = 16'sh0400; end
    run_eval("v029", 16'h0000, N, 0, 1'b0);
    check_eq("v029_exact_z", 32'(z), 32'hF000);
    check_eq("v029_exact_a1", 32'(a1), 32'h0000);
    for (int i = 0; i < N; i++) begin xv[i] = 16'sh7C00; wv[i] = 16'sh7C00; end
    run_eval("v030", 16'h7FFF, N, 0, 1'b0);
    check_eq("v030_exact", 32'(a1), 32'h7FFF);
    load_028();
    run_eval("v031", 16'h0100, 2, 3, 1'b0);

    // Abort after beat 2 (z currently 0x0500)
    p0 = pulses;
    bias = 16'h0100; step = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      x_in = xv[i]; w_in = wv[i]; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("abort_z", 32'(z), 32'd0);
    check_eq("abort_a1", 32'(a1), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_valid", 32'(a1_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("abort_pulses", 32'(pulses - p0), 32'd0);
    run_eval("after_abort", 16'h0100, N, 0, 1'b0);
    check_eq("after_abort_exact", 32'(z), 32'h0500);

    // start with step==0 is ignored; beats in IDLE are ignored too
    p0 = pulses;
    zkeep = z;
    step = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("step0_busy", 32'(busy), 32'd0);
    for (int i = 0; i < N + 1; i++) begin
      x_in = 16'($urandom); w_in = 16'($urandom); in_valid = 1'b1;
      @(negedge clk);
      check_eq("step0_busy_beats", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("step0_pulses", 32'(pulses - p0), 32'd0);
    check_eq("step0_z_hold", 32'(z), 32'(zkeep));

    // start during ACC is ignored
    load_028();
    run_eval("poke", 16'h0100, 1, 2, 1'b1);

    // Randomized evaluations
    for (int t = 0; t < 24; t++) begin
      bit big;
      big = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (big) begin
          xv[i] = 16'($urandom);
          wv[i] = 16'($urandom);
        end else begin
          xv[i] = 16'($signed(12'($urandom)));
          wv[i] = 16'($signed(12'($urandom)));
        end
      end
      repeat ($urandom_range(0, 2)) begin
        in_valid = $urandom_range(0, 1) == 1;
        x_in = 16'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b0;
      run_eval("rand", 16'($urandom), $urandom_range(0, N), $urandom_range(0, 3),
               $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fwd_neuron_module

`default_nettype wire

// File: doc/fwd_neuron_module.md
FWD_NEURON_MODULE -- requirements
Module: fwd_neuron_module

Interface
REQ-001 SHALL have parameter N_IN, default 4: number of input/weight pairs per neuron evaluation (2..15).
REQ-002 SHALL have parameter FRAC, default 10: fractional bits of the Q6.10 operand format.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port step  input  4: current episode step; a start is accepted only when step != 0.
REQ-006 SHALL have port start  input  1: one-cycle request to begin a neuron evaluation.
REQ-007 SHALL have port in_valid  input  1: x_in/w_in pair is valid this cycle.
REQ-008 SHALL have port x_in  input  16 signed: input activation, Q6.10.
REQ-009 SHALL have port w_in  input  16 signed: weight, Q6.10.
REQ-010 SHALL have port bias  input  16 signed: neuron bias, Q6.10, sampled in FINISH.
REQ-011 SHALL have port busy  output  1: high in ACC and FINISH.
REQ-012 SHALL have port z  output  16 signed: registered pre-activation, Q6.10, for back prop.
REQ-013 SHALL have port a1  output  16 signed: registered ReLU activation, Q6.10; feeds the a-hold register downstream.
REQ-014 SHALL have port a1_valid  output  1: one-cycle pulse when z/a1 update.

Function
REQ-015 SHALL implement FSM IDLE -> ACC -> FINISH -> IDLE.
REQ-016 IDLE: start=1 and step!=0 -> clear accumulator and beat counter, go ACC next cycle; start with step==0 ignored; in_valid ignored.
REQ-017 ACC: each cycle with in_valid=1 SHALL add x_in*w_in (full 32-bit signed product) into a signed accumulator of at least 32+ceil(log2(N_IN)) bits and increment the beat counter.
REQ-018 ACC: in_valid=0 cycles SHALL hold accumulator and counter (gaps allowed, no timeout).
REQ-019 ACC: the beat where counter == N_IN-1 and in_valid=1 SHALL transition to FINISH.
REQ-020 FINISH: sum = acc + (bias sign-extended, shifted left FRAC); z = sum arithmetic-shifted right FRAC (truncate toward minus infinity), saturated to [0x8000, 0x7FFF].
REQ-021 FINISH: a1 = 0 if z < 0, else z; z, a1 registered and a1_valid=1 for exactly that one cycle; next state IDLE.
REQ-022 Latency: a1_valid asserts on the clock edge after the last accepted beat (one cycle).
REQ-023 start while busy SHALL be ignored; no queuing.
REQ-024 z and a1 SHALL hold their last value until the next FINISH.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, accumulator 0, counter 0, z 0, a1 0, a1_valid 0, busy 0, including mid-evaluation; the aborted evaluation produces no a1_valid.

Structure
REQ-026 Q-format constants (width 16, FRAC 10, SAT_MAX 0x7FFF, SAT_MIN 0x8000) and FSM state encoding SHALL reside in a shared package used by forward and back prop blocks.
REQ-027 Shift-and-saturate SHALL be a sub-module q_sat_module (wide signed in, 16-bit out), reusable by back prop.

Verification
REQ-028 x={0x0400,0x0800,0x0200,0xFC00}, w={0x0200,0x0200,0x0400,0x0400}, bias 0x0100 -> z=a1=0x0500, a1_valid one cycle after beat 4.
REQ-029 x all 0xFC00, w all 0x0400, bias 0 -> z=0xF000, a1=0x0000.
REQ-030 x all 0x7C00, w all 0x7C00, bias 0x7FFF -> z=a1=0x7FFF (saturated).
REQ-031 Same vectors as REQ-028 with in_valid low for 3 cycles between beats 2 and 3 -> identical result, busy high throughout.
REQ-032 rst_n low after beat 2 -> all outputs 0 immediately, no a1_valid; fresh REQ-028 run then gives 0x0500.
REQ-033 start with step=0 -> stays IDLE; start during ACC -> ignored, result unchanged.
